// File: rtl/memory_stage_lsu.sv
// memory_stage_lsu: memory-stage load/store unit of the 5-stage RISC-V pipeline.
// Issues word loads/stores over a req/ready handshake, stalls the pipeline while
// memory is busy, registers the M/W pipeline outputs and returns M-stage values
// for forwarding and hazard detection.
// Optional feature: define LSU_TIMEOUT_EN to compile in a WAIT-state watchdog
// that forces completion after TIMEOUT cycles and raises a sticky bus_err.

module memory_stage_lsu #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [4:0]  RD_M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] PCPlus4M,

    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,

    output logic        StallM,

    output logic [31:0] ALUResultM_E,
    output logic [4:0]  RD_M_H,
    output logic        RegWriteM_H,

    output logic        RegWriteW,
    output logic [1:0]  ResultSrcW,
    output logic [4:0]  RD_W,
    output logic [31:0] ALUResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,

    output logic        bus_err
);

    localparam int CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]      state;
    logic [CntW-1:0] waitCnt;

    logic access;
    logic isStore;
    logic accept;
    logic timeout;

    // Access decode: any store, or a load selected by the writeback mux.
    assign access  = MemWriteM | (ResultSrcM == 2'b01);
    assign isStore = MemWriteM;

    // Request is raised in both states whenever the E/M instruction touches memory;
    // address and data stay stable because the E/M register is frozen while stalled.
    assign dmem_req   = access & ((state == IDLE) | (state == WAIT));
    assign dmem_we    = isStore;
    assign dmem_addr  = {ALUResultM[31:2], 2'b00};
    assign dmem_wdata = WriteDataM;

    assign accept = dmem_req & dmem_ready;

`ifdef LSU_TIMEOUT_EN
    // Watchdog fires for one cycle once WAIT has lasted TIMEOUT cycles without ready.
    assign timeout = (state == WAIT) & (waitCnt == CntMax) & ~dmem_ready;
    assign StallM  = access & ~accept & ~timeout;
`else
    assign timeout = 1'b0;
    assign StallM  = access & ~accept;
`endif

    assign ALUResultM_E = ALUResultM;
    assign RD_M_H       = RD_M;
    assign RegWriteM_H  = RegWriteM;

    // Handshake FSM: leave IDLE when memory is not ready, count cycles spent waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            waitCnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (access && !dmem_ready) begin
                        state   <= WAIT;
                        waitCnt <= CntW'(1);
                    end
                end
                WAIT: begin
                    if (accept || timeout) begin
                        state   <= IDLE;
                        waitCnt <= '0;
                    end else if (waitCnt != CntMax) begin
                        waitCnt <= waitCnt + CntW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    waitCnt <= '0;
                end
            endcase
        end
    end

    // M/W pipeline register: load the M-stage instruction, or insert a bubble while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            RD_W       <= 5'd0;
            ALUResultW <= 32'd0;
            ReadDataW  <= 32'd0;
            PCPlus4W   <= 32'd0;
        end else if (StallM) begin
            RegWriteW <= 1'b0;
        end else begin
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
            RD_W       <= RD_M;
            ALUResultW <= ALUResultM;
            PCPlus4W   <= PCPlus4M;
            if (access && !isStore) begin
                if (timeout) begin
                    ReadDataW <= 32'd0;
                end else if (accept) begin
                    ReadDataW <= dmem_rdata;
                end
            end
        end
    end

`ifdef LSU_TIMEOUT_EN
    // Sticky bus error: set by any watchdog expiry, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus_err <= 1'b0;
        end else if (timeout) begin
            bus_err <= 1'b1;
        end
    end
`else
    assign bus_err = 1'b0;
`endif

endmodule

// File: tb/tb_memory_stage_lsu.sv
// tb_memory_stage_lsu: directed-vector bench for memory_stage_lsu.
// Inputs change 1 time unit after the rising edge; combinational outputs are
// sampled on the falling edge and registered W outputs 1 unit after the rising edge.

module tb_memory_stage_lsu;

    logic        clk;
    logic        rst;
    logic        RegWriteM;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] PCPlus4M;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        StallM;
    logic [31:0] ALUResultM_E;
    logic [4:0]  RD_M_H;
    logic        RegWriteM_H;
    logic        RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] ALUResultW;
    logic [31:0] ReadDataW;
    logic [31:0] PCPlus4W;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    memory_stage_lsu #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .RegWriteM    (RegWriteM),
        .MemWriteM    (MemWriteM),
        .ResultSrcM   (ResultSrcM),
        .RD_M         (RD_M),
        .ALUResultM   (ALUResultM),
        .WriteDataM   (WriteDataM),
        .PCPlus4M     (PCPlus4M),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_ready   (dmem_ready),
        .dmem_rdata   (dmem_rdata),
        .StallM       (StallM),
        .ALUResultM_E (ALUResultM_E),
        .RD_M_H       (RD_M_H),
        .RegWriteM_H  (RegWriteM_H),
        .RegWriteW    (RegWriteW),
        .ResultSrcW   (ResultSrcW),
        .RD_W         (RD_W),
        .ALUResultW   (ALUResultW),
        .ReadDataW    (ReadDataW),
        .PCPlus4W     (PCPlus4W),
        .bus_err      (bus_err)
    );

    // 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the full set of M-stage and memory inputs.
    task automatic applyStimulus(input logic rw, input logic mw, input logic [1:0] rs,
                                 input logic [4:0] rd, input logic [31:0] alu,
                                 input logic [31:0] wd, input logic [31:0] pc4,
                                 input logic rdy, input logic [31:0] rdata);
        RegWriteM  = rw;
        MemWriteM  = mw;
        ResultSrcM = rs;
        RD_M       = rd;
        ALUResultM = alu;
        WriteDataM = wd;
        PCPlus4M   = pc4;
        dmem_ready = rdy;
        dmem_rdata = rdata;
    endtask

    task automatic nextEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (RegWriteW !== 1'b0 || RD_W !== 5'd0 || ALUResultW !== 32'd0 || ReadDataW !== 32'd0 ||
            PCPlus4W !== 32'd0 || ResultSrcW !== 2'b00 || bus_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_init: got rw=%b rd=%0d alu=%h rdata=%h pc4=%h rs=%b err=%b, need all 0",
                     RegWriteW, RD_W, ALUResultW, ReadDataW, PCPlus4W, ResultSrcW, bus_err);
        end
        rst = 1'b1;
        nextEdge();
        // ALU op so the W register holds nonzero values before the reset.
        applyStimulus(1'b1, 1'b0, 2'b00, 5'd9, 32'h55, 32'd0, 32'h20, 1'b0, 32'd0);
        nextEdge();
        checks++;
        if (RD_W !== 5'd9 || ALUResultW !== 32'h55 || RegWriteW !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_preload: got rd=%0d alu=%h rw=%b, need rd=9 alu=55 rw=1",
                     RD_W, ALUResultW, RegWriteW);
        end
        // Load to 0x100 with memory not ready for three cycles.
        applyStimulus(1'b1, 1'b0, 2'b01, 5'd3, 32'h100, 32'd0, 32'h24, 1'b0, 32'hFFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (StallM !== 1'b1 || dmem_req !== 1'b1) begin
                errors++;
                $display("[TB] FAIL reset_wait_stall: cycle %0d got stall=%b req=%b, need 1/1", i, StallM, dmem_req);
            end
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (RegWriteW !== 1'b0 || RD_W !== 5'd0 || ALUResultW !== 32'd0 || ReadDataW !== 32'd0 ||
            PCPlus4W !== 32'd0 || ResultSrcW !== 2'b00 || bus_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_midwait: got rw=%b rd=%0d alu=%h rdata=%h pc4=%h rs=%b err=%b, need all 0",
                     RegWriteW, RD_W, ALUResultW, ReadDataW, PCPlus4W, ResultSrcW, bus_err);
        end
        applyStimulus(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0);
        #1;
        checks++;
        if (dmem_req !== 1'b0 || StallM !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_req_drop: got req=%b stall=%b, need 0/0", dmem_req, StallM);
        end
        @(negedge clk);
        rst = 1'b1;
        nextEdge();
    endtask

    task automatic test_zero_wait_load();
        $display("[TB] test_zero_wait_load");
        applyStimulus(1'b1, 1'b0, 2'b01, 5'd5, 32'h0000_1006, 32'd0, 32'h44, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        checks++;
        if (dmem_addr !== 32'h0000_1004 || StallM !== 1'b0 || dmem_req !== 1'b1 || dmem_we !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zw_load_req: got addr=%h stall=%b req=%b we=%b, need 1004/0/1/0",
                     dmem_addr, StallM, dmem_req, dmem_we);
        end
        nextEdge();
        checks++;
        if (ReadDataW !== 32'hDEAD_BEEF || RD_W !== 5'd5 || RegWriteW !== 1'b1 || ResultSrcW !== 2'b01) begin
            errors++;
            $display("[TB] FAIL zw_load_w: got rdata=%h rd=%0d rw=%b rs=%b, need deadbeef/5/1/01",
                     ReadDataW, RD_W, RegWriteW, ResultSrcW);
        end
    endtask

    task automatic test_store_waits();
        int stallCnt = 0;
        int acceptCnt = 0;
        $display("[TB] test_store_waits");
        applyStimulus(1'b0, 1'b1, 2'b00, 5'd0, 32'h200, 32'h1234_5678, 32'h48, 1'b0, 32'd0);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            dmem_ready = (cyc == 4);
            @(negedge clk);
            if (StallM === 1'b1) stallCnt++;
            if (dmem_req === 1'b1 && dmem_ready === 1'b1) acceptCnt++;
            checks++;
            if (dmem_we !== 1'b1 || dmem_addr !== 32'h200 || dmem_wdata !== 32'h1234_5678) begin
                errors++;
                $display("[TB] FAIL store_bus: cycle %0d got we=%b addr=%h wdata=%h, need 1/200/12345678",
                         cyc, dmem_we, dmem_addr, dmem_wdata);
            end
            nextEdge();
            if (cyc < 4) begin
                checks++;
                if (RegWriteW !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL store_bubble: cycle %0d got RegWriteW=%b, need 0", cyc, RegWriteW);
                end
            end
        end
        checks++;
        if (stallCnt != 3 || acceptCnt != 1) begin
            errors++;
            $display("[TB] FAIL store_counts: got stalls=%0d accepts=%0d, need 3/1", stallCnt, acceptCnt);
        end
    endtask

    task automatic test_back_to_back();
        int stallCnt = 0;
        $display("[TB] test_back_to_back");
        applyStimulus(1'b1, 1'b0, 2'b01, 5'd6, 32'h300, 32'd0, 32'h50, 1'b1, 32'hAAAA_0001);
        @(negedge clk);
        checks++;
        if (StallM !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_first_stall: got %b, need 0", StallM);
        end
        nextEdge();
        checks++;
        if (ReadDataW !== 32'hAAAA_0001 || RD_W !== 5'd6 || RegWriteW !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_first_w: got rdata=%h rd=%0d rw=%b, need aaaa0001/6/1",
                     ReadDataW, RD_W, RegWriteW);
        end
        applyStimulus(1'b1, 1'b0, 2'b01, 5'd7, 32'h304, 32'd0, 32'h54, 1'b0, 32'h0000_0BAD);
        for (int cyc = 1; cyc <= 3; cyc++) begin
            if (cyc == 3) begin
                dmem_ready = 1'b1;
                dmem_rdata = 32'hBBBB_0002;
            end
            @(negedge clk);
            if (StallM === 1'b1) stallCnt++;
            checks++;
            if (dmem_req !== 1'b1 || dmem_addr !== 32'h304) begin
                errors++;
                $display("[TB] FAIL b2b_second_req: cycle %0d got req=%b addr=%h, need 1/304", cyc, dmem_req, dmem_addr);
            end
            nextEdge();
            if (cyc < 3) begin
                checks++;
                if (RegWriteW !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL b2b_bubble: cycle %0d got RegWriteW=%b, need 0", cyc, RegWriteW);
                end
            end
        end
        checks++;
        if (stallCnt != 2 || ReadDataW !== 32'hBBBB_0002 || RD_W !== 5'd7 || RegWriteW !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_second_w: got stalls=%0d rdata=%h rd=%0d rw=%b, need 2/bbbb0002/7/1",
                     stallCnt, ReadDataW, RD_W, RegWriteW);
        end
        applyStimulus(1'b0, 1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'h58, 1'b0, 32'd0);
        nextEdge();
        checks++;
        if (RegWriteW !== 1'b0 || ReadDataW !== 32'hBBBB_0002) begin
            errors++;
            $display("[TB] FAIL b2b_no_dup: got rw=%b rdata=%h, need 0/bbbb0002", RegWriteW, ReadDataW);
        end
    endtask

    task automatic test_alu_op();
        $display("[TB] test_alu_op");
        applyStimulus(1'b1, 1'b0, 2'b00, 5'd8, 32'd7, 32'h99, 32'h5C, 1'b0, 32'h1111_1111);
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b0 || StallM !== 1'b0 || ALUResultM_E !== 32'd7 || RD_M_H !== 5'd8 || RegWriteM_H !== 1'b1) begin
            errors++;
            $display("[TB] FAIL alu_comb: got req=%b stall=%b fwd=%h rdh=%0d rwh=%b, need 0/0/7/8/1",
                     dmem_req, StallM, ALUResultM_E, RD_M_H, RegWriteM_H);
        end
        nextEdge();
        checks++;
        if (ALUResultW !== 32'd7 || RegWriteW !== 1'b1 || RD_W !== 5'd8 || ResultSrcW !== 2'b00 ||
            ReadDataW !== 32'hBBBB_0002 || PCPlus4W !== 32'h5C) begin
            errors++;
            $display("[TB] FAIL alu_w: got alu=%h rw=%b rd=%0d rs=%b rdata=%h pc4=%h, need 7/1/8/00/bbbb0002/5c",
                     ALUResultW, RegWriteW, RD_W, ResultSrcW, ReadDataW, PCPlus4W);
        end
        applyStimulus(1'b1, 1'b0, 2'b10, 5'd1, 32'h0000_0ABC, 32'd0, 32'h0000_0040, 1'b0, 32'd0);
        nextEdge();
        checks++;
        if (PCPlus4W !== 32'h40 || ResultSrcW !== 2'b10 || RD_W !== 5'd1 || ALUResultW !== 32'h0ABC) begin
            errors++;
            $display("[TB] FAIL jal_w: got pc4=%h rs=%b rd=%0d alu=%h, need 40/10/1/abc",
                     PCPlus4W, ResultSrcW, RD_W, ALUResultW);
        end
`ifndef LSU_TIMEOUT_EN
        checks++;
        if (bus_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bus_err_tied: got %b, need 0", bus_err);
        end
`endif
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        int stallCnt = 0;
        logic done = 1'b0;
        $display("[TB] test_timeout");
        applyStimulus(1'b1, 1'b0, 2'b01, 5'd10, 32'h400, 32'd0, 32'h60, 1'b0, 32'h0000_0077);
        for (int cyc = 0; cyc < 10 && !done; cyc++) begin
            @(negedge clk);
            if (StallM === 1'b1) stallCnt++;
            else done = 1'b1;
            nextEdge();
        end
        checks++;
        if (!done || stallCnt != 4) begin
            errors++;
            $display("[TB] FAIL timeout_stall: got stalls=%0d completed=%b, need 4/1", stallCnt, done);
        end
        checks++;
        if (ReadDataW !== 32'd0 || RegWriteW !== 1'b1 || RD_W !== 5'd10 || bus_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_w: got rdata=%h rw=%b rd=%0d err=%b, need 0/1/10/1",
                     ReadDataW, RegWriteW, RD_W, bus_err);
        end
        applyStimulus(1'b1, 1'b0, 2'b01, 5'd11, 32'h404, 32'd0, 32'h64, 1'b1, 32'h0000_0123);
        nextEdge();
        checks++;
        if (bus_err !== 1'b1 || ReadDataW !== 32'h123) begin
            errors++;
            $display("[TB] FAIL timeout_sticky: got err=%b rdata=%h, need 1/123", bus_err, ReadDataW);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_wait_load();
        test_store_waits();
        test_back_to_back();
        test_alu_op();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_stage_lsu.md
# memory_stage_lsu

Memory-stage load/store unit for the 5-stage RISC-V pipeline, sitting downstream of the execute stage's E/M pipeline register and upstream of writeback. It consumes the registered execute results, issues word load/store requests to a data memory over a req/ready handshake, stalls the pipeline while memory is busy, and registers the M/W pipeline outputs. It also returns the M-stage ALU result and destination register for forwarding and hazard detection.

## Interface
Parameters:
- TIMEOUT, 16, maximum WAIT cycles before forced completion (only used when the watchdog is compiled in)

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous active-low reset
- RegWriteM, MemWriteM  input  1 each  control from E/M register
- ResultSrcM  input  2  00 ALU, 01 load data, 10 PC+4
- RD_M  input  5  destination register
- ALUResultM, WriteDataM, PCPlus4M  input  32 each  address/ALU result, store data, PC+4
- dmem_req  output  1  memory request valid
- dmem_we  output  1  1 = store, 0 = load
- dmem_addr  output  32  {ALUResultM[31:2], 2'b00}
- dmem_wdata  output  32  WriteDataM
- dmem_ready  input  1  memory accepts/completes request this cycle
- dmem_rdata  input  32  load data, valid when dmem_ready
- StallM  output  1  freezes PC, F/D, D/E and E/M registers; inserts a bubble into W
- ALUResultM_E  output  32  ALUResultM forwarded to execute
- RD_M_H, RegWriteM_H  output  5/1  to hazard unit
- RegWriteW, ResultSrcW[1:0], RD_W[4:0], ALUResultW[31:0], ReadDataW[31:0], PCPlus4W[31:0]  output  M/W register
- bus_err  output  1  sticky timeout flag

## Operation
- access = MemWriteM | (ResultSrcM == 2'b01); is_store = MemWriteM.
- dmem_req = access in IDLE or WAIT; dmem_we = is_store; address/data are combinational from inputs and stable because the E/M register is frozen during a stall.
- accept = dmem_req & dmem_ready. StallM = access & ~accept (& ~timeout when compiled in).
- FSM, two states:
  - IDLE: access & ~dmem_ready -> WAIT, wait_cnt <= 1. Otherwise stay.
  - WAIT: accept -> IDLE, wait_cnt <= 0. Otherwise wait_cnt increments, saturating at TIMEOUT.
- M/W register, updated every cycle:
  - ~StallM: RegWriteW, ResultSrcW, RD_W, ALUResultW, PCPlus4W <= M-stage values; ReadDataW <= dmem_rdata on a load accept, otherwise holds its previous value.
  - StallM: RegWriteW <= 0 (bubble); other W fields hold.
- Non-access instructions never stall and pass through in one cycle.
- RD_M_H = RD_M, RegWriteM_H = RegWriteM, and ALUResultM_E = ALUResultM, all combinational.
- wait_cnt width is $clog2(TIMEOUT+1).

## Timing
- Reset (rst = 0, asynchronous): state IDLE, wait_cnt 0, all W outputs 0, and bus_err 0. Combinational outputs follow their inputs.
- Zero-wait access (ready in the first cycle): no stall; W valid on the next edge.
- Access with N wait cycles: StallM is high for N cycles; W updates on the edge following accept.
- Back-to-back accesses: the second access is presented the cycle after the first is accepted and requests immediately from IDLE.
- Reset during WAIT: the request is abandoned, dmem_req drops with access, and the FSM returns to IDLE.

## Configuration
- LSU_TIMEOUT_EN defined:
  - In WAIT with wait_cnt == TIMEOUT and ~dmem_ready, timeout = 1 for one cycle.
  - The access completes: StallM = 0, the W register loads, ReadDataW <= 0 for a load, and a store is dropped.
  - bus_err <= 1, sticky until reset. The FSM returns to IDLE.
- LSU_TIMEOUT_EN undefined: no watchdog and no timeout logic. WAIT persists indefinitely; bus_err is tied to 0.

## Test plan
- Reset mid-WAIT: load to 0x100, ready held low 3 cycles, then rst pulsed -> state IDLE, all W outputs 0, bus_err 0, RegWriteW 0.
- Zero-wait load: ResultSrcM = 01, ALUResultM = 0x0000_1006, ready = 1, rdata = 0xDEAD_BEEF, RD_M = 5 -> dmem_addr = 0x1004, StallM never high, next edge ReadDataW = 0xDEAD_BEEF, RD_W = 5, RegWriteW = 1.
- Store with 3 waits: MemWriteM = 1, WriteDataM = 0x1234_5678, ready on cycle 4 -> StallM high exactly 3 cycles, RegWriteW = 0 during the stall, dmem_we = 1, single accept.
- Back-to-back loads with 0 and 2 waits -> W sequence correct, stall only on the second, no duplicate RegWriteW pulse.
- Non-memory ALU op (ResultSrcM = 00, RegWriteM = 1, ALUResultM = 7) -> dmem_req 0, ALUResultW = 7 next edge.
- LSU_TIMEOUT_EN with TIMEOUT = 4, ready never asserted -> StallM high 4 cycles, then completes with ReadDataW = 0, bus_err = 1 persisting across later accesses.
